wb_copy_master: RTL and testbench

WB_COPY_MASTER -- requirements
Module: wb_copy_master

---
 rtl/wb_copy_pkg.sv | 45 ++++
 rtl/wb_ack_timer.sv | 32 +++
 rtl/wb_copy_master.sv | 187 ++++++++++++++++++
 tb/tb_wb_copy_master.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_copy_pkg.sv
// Shared types and constants for the Wishbone word-copy master.
package wb_copy_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;

    localparam logic [SEL_W-1:0]  SEL_ALL   = 4'hF;
    localparam logic [ADDR_W-1:0] ADDR_STEP = 32'd4;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        FIN,
        ERR
    } state_t;

    // Master-side request payload: everything the master drives onto the bus.
    typedef struct packed {
        logic              cyc;
        logic              stb;
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] dat;
    } wb_req_t;

    localparam wb_req_t WB_REQ_IDLE = '0;

    // Full-word request with cyc/stb raised.
    function automatic wb_req_t wb_req(input logic              we,
                                       input logic [ADDR_W-1:0] adr,
                                       input logic [DATA_W-1:0] dat);
        wb_req_t r;
        r.cyc = 1'b1;
        r.stb = 1'b1;
        r.we  = we;
        r.sel = SEL_ALL;
        r.adr = adr;
        r.dat = dat;
        return r;
    endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Per-transfer ack watchdog: counts strobe cycles without ack and flags the last allowed one.
module wb_ack_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_q;

    // Saturating count of waited cycles, restarted whenever a new strobe begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (run && (count_q != CNT_SAT)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // High during the TIMEOUT-th waiting cycle; run already excludes an ack in that cycle.
    assign expired = run && (count_q == CNT_LAST);

endmodule

// File: rtl/wb_copy_master.sv
// Wishbone classic master that copies len_i words from src_i to dst_i, one read/write pair per word.
module wb_copy_master
    import wb_copy_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned LEN_W   = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic [31:0]       src_i,
    input  logic [31:0]       dst_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [LEN_W-1:0]  words_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic [31:0]       wbm_adr_o,
    output logic [31:0]       wbm_dat_o,
    input  logic [31:0]       wbm_dat_i,
    input  logic              wbm_ack_i
);

    state_t             state_q, state_n;
    wb_req_t            bus_q, bus_n;
    logic [ADDR_W-1:0]  src_q, src_n;
    logic [ADDR_W-1:0]  dst_q, dst_n;
    logic [LEN_W-1:0]   len_q, len_n;
    logic [LEN_W-1:0]   words_q, words_n;
    logic [DATA_W-1:0]  data_q, data_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;
    logic               err_q, err_n;

    logic               ack_c;
    logic               timer_run_c;
    logic               timer_clear_c;
    logic               expired;

    // Acks only count while a strobe is actually on the bus.
    assign ack_c         = wbm_ack_i && bus_q.cyc && bus_q.stb;
    assign timer_run_c   = bus_q.stb && !wbm_ack_i;
    assign timer_clear_c = bus_n.stb && !bus_q.stb;

    wb_ack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_ack_timer (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clear   (timer_clear_c),
        .run     (timer_run_c),
        .expired (expired)
    );

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        state_n = state_q;
        bus_n   = bus_q;
        src_n   = src_q;
        dst_n   = dst_q;
        len_n   = len_q;
        words_n = words_q;
        data_n  = data_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        err_n   = err_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    src_n   = src_i;
                    dst_n   = dst_i;
                    len_n   = len_i;
                    words_n = '0;
                    err_n   = 1'b0;
                    busy_n  = 1'b1;
                    if (len_i == '0) begin
                        state_n = FIN;
                    end else begin
                        // First read goes out on the very next cycle.
                        state_n = RD;
                        bus_n   = wb_req(1'b0, src_i, '0);
                    end
                end
            end

            RD: begin
                if (!bus_q.stb) begin
                    bus_n = wb_req(1'b0, src_q, '0);
                end else if (ack_c) begin
                    data_n  = wbm_dat_i;
                    bus_n   = WB_REQ_IDLE;
                    state_n = WR;
                end else if (expired) begin
                    bus_n   = WB_REQ_IDLE;
                    state_n = ERR;
                end
            end

            WR: begin
                if (!bus_q.stb) begin
                    bus_n = wb_req(1'b1, dst_q, data_q);
                end else if (ack_c) begin
                    bus_n   = WB_REQ_IDLE;
                    src_n   = src_q + ADDR_STEP;
                    dst_n   = dst_q + ADDR_STEP;
                    words_n = words_q + LEN_W'(1);
                    if (words_n == len_q) begin
                        // Completion is signalled on the same edge as the final ack.
                        state_n = FIN;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        state_n = RD;
                    end
                end else if (expired) begin
                    bus_n   = WB_REQ_IDLE;
                    state_n = ERR;
                end
            end

            FIN: begin
                // A zero-length copy arrives here without a pending done pulse.
                if (!done_q) begin
                    done_n = 1'b1;
                    busy_n = 1'b0;
                end else begin
                    state_n = IDLE;
                end
            end

            ERR: begin
                err_n   = 1'b1;
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
                bus_n   = WB_REQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            bus_q   <= WB_REQ_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            words_q <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            bus_q   <= bus_n;
            src_q   <= src_n;
            dst_q   <= dst_n;
            len_q   <= len_n;
            words_q <= words_n;
            data_q  <= data_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            err_q   <= err_n;
        end
    end

    assign wbm_cyc_o = bus_q.cyc;
    assign wbm_stb_o = bus_q.stb;
    assign wbm_we_o  = bus_q.we;
    assign wbm_sel_o = bus_q.sel;
    assign wbm_adr_o = bus_q.adr;
    assign wbm_dat_o = bus_q.dat;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign words_o   = words_q;

endmodule

// File: tb/tb_wb_copy_master.sv
// Scoreboard bench for wb_copy_master: a copy-level model queues expected bus transfers and completions.
module tb_wb_copy_master;

    localparam int unsigned TO = 64;
    localparam int unsigned LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   src;
    logic [31:0]   dst;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          err;
    logic [LW-1:0] words;
    logic          cyc;
    logic          stb;
    logic          we;
    logic [3:0]    sel;
    logic [31:0]   adr;
    logic [31:0]   dat_o;
    logic [31:0]   dat_i;
    logic          ack;

    int npass   = 0;
    int nchecks = 0;

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        bit          timeout;
        bit          first;
    } xfer_t;

    // lat: 0 unchecked, 1 one cycle after last ack, 2 two cycles after start
    typedef struct {
        int words;
        bit err;
        int lat;
    } done_t;

    xfer_t exp_x[$];
    done_t exp_d[$];

    int          ack_delay   = 1;
    bit          hang_writes = 1'b0;
    bit          junk_ack    = 1'b0;
    bit          mon_clear   = 1'b0;
    logic [31:0] seed;

    wb_copy_master #(
        .TIMEOUT (TO),
        .LEN_W   (LW)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .start_i   (start),
        .src_i     (src),
        .dst_i     (dst),
        .len_i     (len),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err),
        .words_o   (words),
        .wbm_cyc_o (cyc),
        .wbm_stb_o (stb),
        .wbm_we_o  (we),
        .wbm_sel_o (sel),
        .wbm_adr_o (adr),
        .wbm_dat_o (dat_o),
        .wbm_dat_i (dat_i),
        .wbm_ack_i (ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] expv);
        nchecks++;
        if (ok) npass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, expv, $time);
    endtask

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] expv);
        chk(act === expv, name, act, expv);
    endtask

    // Slave memory contents as a pure function of address.
    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ seed;
    endfunction

    // Copy-level reference: word i reads src+4i, then writes that word to dst+4i.
    task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int l, input bit hang);
        if (l == 0) begin
            exp_d.push_back('{0, 1'b0, 2});
        end else begin
            for (int i = 0; i < l; i++) begin
                logic [31:0] ra;
                logic [31:0] wa;
                ra = s + 32'(4 * i);
                wa = d + 32'(4 * i);
                exp_x.push_back('{1'b0, ra, 32'h0, 1'b0, (i == 0)});
                if (hang) begin
                    exp_x.push_back('{1'b1, wa, data_of(ra), 1'b1, 1'b0});
                    exp_d.push_back('{i, 1'b1, 0});
                    return;
                end
                exp_x.push_back('{1'b1, wa, data_of(ra), 1'b0, 1'b0});
            end
            exp_d.push_back('{l, 1'b0, 1});
        end
    endtask

    task automatic issue(input logic [31:0] s, input logic [31:0] d, input int l, input bit hang);
        model_copy(s, d, l, hang);
        @(posedge clk); #1;
        start = 1'b1;
        src   = s;
        dst   = d;
        len   = LW'(l);
        @(posedge clk); #1;
        start = 1'b0;
        src   = $urandom;
        dst   = $urandom;
        len   = LW'($urandom);
        @(negedge clk);
        chk_eq("busy_after_start", 32'(busy), 32'd1);
        chk_eq("err_cleared_on_start", 32'(err), 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_x.size() != 0 || exp_d.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk_eq("job_finished_in_budget", 32'(exp_x.size() + exp_d.size()), 32'd0);
        exp_x.delete();
        exp_d.delete();
        repeat (2) @(negedge clk);
    endtask

    // Slave: acks after ack_delay waited cycles; optionally stalls writes or toggles ack off-strobe.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        ack      = 1'b0;
        dat_i    = '0;
        forever begin
            @(posedge clk); #2;
            if (cyc && stb && !rst) begin
                if (!(hang_writes && we) && wait_cnt >= ack_delay) begin
                    ack   = 1'b1;
                    dat_i = we ? 32'($urandom) : data_of(adr);
                end else begin
                    ack = 1'b0;
                end
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                ack      = junk_ack ? 1'($urandom_range(0, 1)) : 1'b0;
                dat_i    = $urandom;
            end
        end
    end

    int    cyc_cnt = 0;
    int    start_cycle = 0;
    int    last_ack_cycle = 0;
    int    fall_cycle = 0;
    int    hi_len = 0;
    bit    have_prev = 1'b0;
    bit    cur_valid = 1'b0;
    bit    acked = 1'b0;
    bit    prev_stb = 1'b0;
    bit    prev_done = 1'b0;
    xfer_t cur;
    done_t dq;

    // Monitor: pops expectations whenever the DUT starts/ends a transfer or pulses done.
    initial begin
        forever begin
            @(negedge clk);
            cyc_cnt++;
            if (rst || mon_clear) begin
                mon_clear = 1'b0;
                cur_valid = 1'b0;
                have_prev = 1'b0;
            end else begin
                if (start && !busy) begin
                    start_cycle = cyc_cnt;
                    have_prev   = 1'b0;
                end
                if (stb && !prev_stb) begin
                    chk(exp_x.size() != 0, "transfer_expected", 32'(exp_x.size()), 32'd1);
                    if (exp_x.size() != 0) begin
                        cur       = exp_x.pop_front();
                        cur_valid = 1'b1;
                        acked     = 1'b0;
                        hi_len    = 0;
                        chk_eq("cyc_with_stb", 32'(cyc), 32'd1);
                        chk_eq("adr", adr, cur.adr);
                        chk_eq("we", 32'(we), 32'(cur.we));
                        chk_eq("sel", 32'(sel), 32'hF);
                        if (cur.we) chk_eq("write_data", dat_o, cur.dat);
                        if (have_prev) chk_eq("stb_gap", 32'(cyc_cnt - fall_cycle), 32'd1);
                        if (cur.first) chk_eq("start_to_stb", 32'(cyc_cnt - start_cycle), 32'd1);
                    end
                end
                if (stb) begin
                    hi_len++;
                    if (ack) begin
                        acked          = 1'b1;
                        last_ack_cycle = cyc_cnt;
                    end
                end
                if (!stb && prev_stb) begin
                    fall_cycle = cyc_cnt;
                    have_prev  = 1'b1;
                    if (cur_valid) begin
                        chk_eq("transfer_acked", 32'(acked), 32'(!cur.timeout));
                        if (!acked) chk_eq("timeout_stb_cycles", 32'(hi_len), 32'(TO));
                        cur_valid = 1'b0;
                    end
                end
                if (done) begin
                    chk(exp_d.size() != 0, "done_expected", 32'(exp_d.size()), 32'd1);
                    chk_eq("done_single_cycle", 32'(prev_done), 32'd0);
                    if (exp_d.size() != 0) begin
                        dq = exp_d.pop_front();
                        chk_eq("done_words", 32'(words), 32'(dq.words));
                        chk_eq("done_err", 32'(err), 32'(dq.err));
                        chk_eq("busy_at_done", 32'(busy), 32'd0);
                        if (dq.lat == 1) chk_eq("ack_to_done", 32'(cyc_cnt - last_ack_cycle), 32'd1);
                        if (dq.lat == 2) chk_eq("start_to_done", 32'(cyc_cnt - start_cycle), 32'd2);
                    end
                    have_prev = 1'b0;
                end
            end
            prev_stb  = stb;
            prev_done = done;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", nchecks);
        $fatal(1);
    end

    initial begin
        int n;
        seed  = $urandom;
        rst   = 1'b1;
        start = 1'b0;
        src   = '0;
        dst   = '0;
        len   = '0;

        repeat (2) @(negedge clk);
        chk_eq("rst_cyc", 32'(cyc), 32'd0);
        chk_eq("rst_stb", 32'(stb), 32'd0);
        chk_eq("rst_we", 32'(we), 32'd0);
        chk_eq("rst_sel", 32'(sel), 32'd0);
        chk_eq("rst_adr", adr, 32'd0);
        chk_eq("rst_dat", dat_o, 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_done", 32'(done), 32'd0);
        chk_eq("rst_err", 32'(err), 32'd0);
        chk_eq("rst_words", 32'(words), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic three-word copy with a slow slave.
        ack_delay = 11;
        issue(32'h3800_0000, 32'h3800_0100, 3, 1'b0);
        wait_idle(2000);

        // Zero-length copy.
        issue(32'h0000_1000, 32'h0000_2000, 0, 1'b0);
        wait_idle(100);

        // First write never acknowledged.
        ack_delay   = 2;
        hang_writes = 1'b1;
        issue(32'h0000_1000, 32'h0000_2000, 2, 1'b1);
        wait_idle(500);
        hang_writes = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("err_holds", 32'(err), 32'd1);
        chk_eq("words_hold_after_err", 32'(words), 32'd0);

        // Source wraps past the top of the address space; a start while busy is ignored.
        ack_delay = 3;
        issue(32'hFFFF_FFFC, 32'h0000_0100, 2, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        src   = 32'h0000_5000;
        dst   = 32'h0000_6000;
        len   = LW'(7);
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(1000);

        // Reset while waiting on a write ack.
        ack_delay = 30;
        issue(32'h0000_0400, 32'h0000_0800, 2, 1'b0);
        n = 0;
        while (!(stb && we) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk_eq("reached_write_wait", 32'(stb && we), 32'd1);
        @(posedge clk); #1;
        rst       = 1'b1;
        mon_clear = 1'b1;
        exp_x.delete();
        exp_d.delete();
        @(negedge clk);
        @(negedge clk);
        chk_eq("midrst_cyc", 32'(cyc), 32'd0);
        chk_eq("midrst_stb", 32'(stb), 32'd0);
        chk_eq("midrst_busy", 32'(busy), 32'd0);
        chk_eq("midrst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        ack_delay = 1;
        issue(32'h0000_0400, 32'h0000_0800, 2, 1'b0);
        wait_idle(1000);

        // Zero-wait slave: back-to-back transfers separated by one idle cycle.
        ack_delay = 0;
        issue({$urandom} & 32'hFFFF_FFFC, {$urandom} & 32'hFFFF_FFFC, 5, 1'b0);
        wait_idle(1000);

        // Randomised copies with stray acks between strobes.
        for (int k = 0; k < 12; k++) begin
            ack_delay = int'($urandom_range(0, 4));
            junk_ack  = 1'($urandom_range(0, 1));
            issue({$urandom} & 32'hFFFF_FFFC, {$urandom} & 32'hFFFF_FFFC,
                  int'($urandom_range(0, 5)), 1'b0);
            wait_idle(2000);
        end
        junk_ack = 1'b0;

        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end

endmodule
